// File: rtl/rhythm_hit_judge.sv
// rhythm_hit_judge: two-lane hit judge, score and combo keeper.
// Optional GHOST_PENALTY_EN: stray presses cost a point and the combo.
module rhythm_hit_judge #(
  parameter int unsigned HIT_LO      = 600,
  parameter int unsigned HIT_HI      = 650,
  parameter int unsigned PERF_LO     = 615,
  parameter int unsigned PERF_HI     = 635,
  parameter int unsigned PTS_PERFECT = 3,
  parameter int unsigned PTS_GOOD    = 1,
  parameter int unsigned SCORE_W     = 16
) (
  input  logic               clk_blk,
  input  logic               reset,
  input  logic               userin1,
  input  logic               userin2,
  input  logic [9:0]         block1_bot,
  input  logic [9:0]         block2_bot,
  output logic [SCORE_W-1:0] score,
  output logic [7:0]         combo,
  output logic [7:0]         max_combo,
  output logic               hit1,
  output logic               hit2,
  output logic               perfect1,
  output logic               perfect2,
  output logic               miss1,
  output logic               miss2
);

  localparam int SW2 = SCORE_W + 2;

  localparam logic [9:0] HLO = 10'(HIT_LO);
  localparam logic [9:0] HHI = 10'(HIT_HI);
  localparam logic [9:0] PLO = 10'(PERF_LO);
  localparam logic [9:0] PHI = 10'(PERF_HI);

  localparam logic [SW2-1:0] PP   = SW2'(PTS_PERFECT);
  localparam logic [SW2-1:0] PG   = SW2'(PTS_GOOD);
  localparam logic [SW2-1:0] SMAX = {2'b00, {SCORE_W{1'b1}}};

  typedef enum logic {
    ARMED,
    JUDGED
  } lane_st_e;

  lane_st_e     st       [2];
  logic [9:0]   prev_bot [2];
  logic [9:0]   bot      [2];
  logic [10:0]  prev_p   [2];
  logic [1:0]   u_q;
  logic [1:0]   usr;
  logic         primed;

  logic [1:0]   press;
  logic [1:0]   in_hit;
  logic [1:0]   in_perf;
  logic [1:0]   do_hit;
  logic [1:0]   do_miss;
  logic [1:0]   do_rearm;
`ifdef GHOST_PENALTY_EN
  logic [1:0]   do_stray;
  logic [SW2-1:0] pen;
`endif

  logic [SW2-1:0]     sum;
  logic [8:0]         cinc;
  logic               clr;
  logic [SCORE_W-1:0] score_nx;
  logic [7:0]         combo_nx;

  assign usr    = {userin2, userin1};
  assign bot[0] = block1_bot;
  assign bot[1] = block2_bot;

  // per-lane judgement for the block seen on this edge
  always_comb begin
    press    = '0;
    in_hit   = '0;
    in_perf  = '0;
    do_hit   = '0;
    do_miss  = '0;
    do_rearm = '0;
`ifdef GHOST_PENALTY_EN
    do_stray = '0;
`endif
    for (int i = 0; i < 2; i++) begin
      // a respawn shows up as bot not above the previous sample
      prev_p[i]  = {1'b0, prev_bot[i]} + {10'd0, primed};
      press[i]   = usr[i] & ~u_q[i];
      in_hit[i]  = (bot[i] >= HLO) && (bot[i] < HHI);
      in_perf[i] = (bot[i] >= PLO) && (bot[i] < PHI);
      if (st[i] == ARMED) begin
        if (press[i] && in_hit[i])
          do_hit[i] = 1'b1;
        else if (primed && ({1'b0, bot[i]} < prev_p[i]))
          do_miss[i] = 1'b1;
`ifdef GHOST_PENALTY_EN
        else if (press[i])
          do_stray[i] = 1'b1;
`endif
      end else if (bot[i] < prev_bot[i]) begin
        do_rearm[i] = 1'b1;
      end
    end
  end

  // next score and combo, both saturating
  always_comb begin
    sum = {2'b00, score};
    for (int i = 0; i < 2; i++)
      if (do_hit[i])
        sum = sum + (in_perf[i] ? PP : PG);
    clr = |do_miss;
`ifdef GHOST_PENALTY_EN
    pen = SW2'(do_stray[0]) + SW2'(do_stray[1]);
    sum = (sum < pen) ? '0 : sum - pen;
    clr = clr | (|do_stray);
`endif
    if (sum > SMAX)
      sum = SMAX;
    score_nx = sum[SCORE_W-1:0];
    cinc = {1'b0, combo} + 9'(do_hit[0]) + 9'(do_hit[1]);
    if (cinc > 9'd255)
      cinc = 9'd255;
    combo_nx = clr ? 8'd0 : cinc[7:0];
  end

  // lane state, press history, pulses and counters
  always_ff @(posedge clk_blk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        st[i]       <= ARMED;
        prev_bot[i] <= '0;
      end
      u_q       <= '0;
      primed    <= 1'b0;
      score     <= '0;
      combo     <= '0;
      max_combo <= '0;
      hit1      <= 1'b0;
      hit2      <= 1'b0;
      perfect1  <= 1'b0;
      perfect2  <= 1'b0;
      miss1     <= 1'b0;
      miss2     <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        prev_bot[i] <= bot[i];
        if (do_hit[i])
          st[i] <= JUDGED;
        else if (do_rearm[i])
          st[i] <= ARMED;
      end
      u_q       <= usr;
      primed    <= 1'b1;
      score     <= score_nx;
      combo     <= combo_nx;
      max_combo <= (combo_nx > max_combo) ? combo_nx : max_combo;
      hit1      <= do_hit[0];
      hit2      <= do_hit[1];
      perfect1  <= do_hit[0] & in_perf[0];
      perfect2  <= do_hit[1] & in_perf[1];
      miss1     <= do_miss[0];
      miss2     <= do_miss[1];
    end
  end

endmodule

// File: tb/tb_rhythm_hit_judge.sv
// tb_rhythm_hit_judge: directed and random checks of rhythm_hit_judge
// against a rule-level reference model.
module tb_rhythm_hit_judge;

  logic        clk_blk = 1'b0;
  logic        reset   = 1'b1;
  logic        userin1 = 1'b0;
  logic        userin2 = 1'b0;
  logic [9:0]  block1_bot = '0;
  logic [9:0]  block2_bot = '0;
  logic [15:0] score;
  logic [7:0]  combo;
  logic [7:0]  max_combo;
  logic        hit1, hit2, perfect1, perfect2, miss1, miss2;

  rhythm_hit_judge dut (
    .clk_blk    (clk_blk),
    .reset      (reset),
    .userin1    (userin1),
    .userin2    (userin2),
    .block1_bot (block1_bot),
    .block2_bot (block2_bot),
    .score      (score),
    .combo      (combo),
    .max_combo  (max_combo),
    .hit1       (hit1),
    .hit2       (hit2),
    .perfect1   (perfect1),
    .perfect2   (perfect2),
    .miss1      (miss1),
    .miss2      (miss2)
  );

  always #5 clk_blk = ~clk_blk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // reference model state
  bit m_judged [2];
  bit m_uq     [2];
  int m_prev   [2];
  bit m_primed;
  int m_score, m_combo, m_max;
  bit e_hit [2], e_perf [2], e_miss [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_judged[i] = 0; m_uq[i] = 0; m_prev[i] = 0;
      e_hit[i] = 0; e_perf[i] = 0; e_miss[i] = 0;
    end
    m_primed = 0; m_score = 0; m_combo = 0; m_max = 0;
  endtask

  task automatic model_edge(input int u1, input int u2,
                            input int b1, input int b2);
    int u [2];
    int b [2];
    int pts, nh, pen;
    bit clear, press;
    u[0] = u1; u[1] = u2; b[0] = b1; b[1] = b2;
    pts = 0; nh = 0; pen = 0; clear = 0;
    for (int i = 0; i < 2; i++) begin
      press = (u[i] != 0) && !m_uq[i];
      e_hit[i] = 0; e_perf[i] = 0; e_miss[i] = 0;
      if (!m_judged[i]) begin
        if (press && b[i] >= 600 && b[i] < 650) begin
          e_hit[i] = 1;
          e_perf[i] = (b[i] >= 615 && b[i] < 635);
          m_judged[i] = 1;
          pts += e_perf[i] ? 3 : 1;
          nh++;
        end else if (m_primed && b[i] < m_prev[i] + 1) begin
          e_miss[i] = 1;
          clear = 1;
        end else if (press) begin
`ifdef GHOST_PENALTY_EN
          pen++;
          clear = 1;
`endif
        end
      end else if (b[i] < m_prev[i]) begin
        m_judged[i] = 0;
      end
      m_uq[i] = (u[i] != 0);
      m_prev[i] = b[i];
    end
    m_primed = 1;
    m_score = m_score + pts - pen;
    if (m_score < 0) m_score = 0;
    if (m_score > 65535) m_score = 65535;
    m_combo = clear ? 0 : ((m_combo + nh > 255) ? 255 : m_combo + nh);
    if (m_combo > m_max) m_max = m_combo;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".score"}, score, m_score);
    check({tag, ".combo"}, combo, m_combo);
    check({tag, ".max"}, max_combo, m_max);
    check({tag, ".hit1"}, hit1, e_hit[0]);
    check({tag, ".hit2"}, hit2, e_hit[1]);
    check({tag, ".perf1"}, perfect1, e_perf[0]);
    check({tag, ".perf2"}, perfect2, e_perf[1]);
    check({tag, ".miss1"}, miss1, e_miss[0]);
    check({tag, ".miss2"}, miss2, e_miss[1]);
  endtask

  task automatic step(input string tag, input int u1, input int u2,
                      input int b1, input int b2);
    userin1 = u1[0];
    userin2 = u2[0];
    block1_bot = b1[9:0];
    block2_bot = b2[9:0];
    @(posedge clk_blk);
    model_edge(u1, u2, b1, b2);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    userin1 = 0; userin2 = 0; block1_bot = '0; block2_bot = '0;
    model_reset();
    #1;
    check_all({tag, ".async"});
    repeat (2) @(posedge clk_blk);
    #1;
    check_all({tag, ".held"});
    @(negedge clk_blk);
    reset = 1'b1;
  endtask

  int b1, b2, r1, r2, ru1, ru2;

  initial begin
    #2;
    do_reset("por");

    for (int k = 0; k <= 104; k++)
      step("t1", (k == 104) ? 1 : 0, 0, 100 + 5 * k, 100 + k);
    check("t1_hit1", hit1, 1);
    check("t1_perf1", perfect1, 1);
    check("t1_score", score, 3);
    check("t1_combo", combo, 1);
    check("t1_max", max_combo, 1);
    step("t1d", 0, 0, 100, 205);
    check("t1_nomiss1", miss1, 0);
    check("t1_pulse_end", hit1, 0);

    b2 = 205;
    for (int k = 1; k <= 101; k++) begin
      b2++;
      step("t2", (k == 101) ? 1 : 0, 0, 100 + 5 * k, b2);
    end
    check("t2_hit1", hit1, 1);
    check("t2_good", perfect1, 0);
    check("t2_score", score, 4);
    for (int k = 102; k <= 124; k++) begin
      b2++;
      step("t2h", 1, 0, 100 + 5 * k, b2);
    end
    b2++;
    step("t2r", 1, 0, 100, b2);
    for (int k = 1; k <= 124; k++) begin
      b2++;
      step("t2h2", 1, 0, 100 + 5 * k, b2);
    end
    b2++;
    step("t2m", 1, 0, 100, b2);
    check("t2_hold_score", score, 4);
    check("t2_hold_miss", miss1, 1);

    b1 = 100;
    b1++;
    step("t3a", 1, 0, b1, 100);
    for (int j = 1; j <= 31; j++) begin
      b1++;
      step("t3", 1, 0, b1, 100 + 20 * j);
    end
    b1++;
    step("t3d", 1, 0, b1, 100);
    check("t3_miss2", miss2, 1);
    check("t3_combo", combo, 0);
    check("t3_score", score, 4);
    b1++;
    step("t3e", 1, 0, b1, 120);
    check("t3_miss2_pulse", miss2, 0);

    do_reset("r4");
    b2 = 200;
    for (int n = 0; n < 4; n++) begin
      step("t4a", 0, 0, 100, b2); b2 += 10;
      step("t4b", 1, 0, 620, b2); b2 += 10;
    end
    check("t4_combo4", combo, 4);
    step("t4c", 0, 0, 100, b2);
    step("t4d", 1, 0, 625, 150);
    check("t4_hit1", hit1, 1);
    check("t4_perf1", perfect1, 1);
    check("t4_miss2", miss2, 1);
    check("t4_combo", combo, 0);
    check("t4_score", score, 15);
    check("t4_max", max_combo, 4);

    step("t5a", 0, 0, 100, 160);
    step("t5b", 1, 0, 620, 170);
    step("t5c", 0, 0, 100, 180);
    step("t5d", 0, 0, 200, 190);
    step("t5e", 1, 0, 300, 200);
`ifdef GHOST_PENALTY_EN
    check("t5_stray_score", score, 17);
    check("t5_stray_combo", combo, 0);
`else
    check("t5_stray_score", score, 18);
    check("t5_stray_combo", combo, 1);
`endif

    step("t6a", 0, 0, 400, 210);
    step("t6b", 1, 0, 610, 220);
    check("t6_hit1", hit1, 1);
    #2;
    do_reset("t6");
    check("t6_hit_cleared", hit1, 0);
    check("t6_score_cleared", score, 0);

    r1 = 100; r2 = 100; ru1 = 0; ru2 = 0;
    for (int n = 0; n < 3000; n++) begin
      r1 += $urandom_range(3, 15);
      if (r1 > 720) r1 = $urandom_range(60, 140);
      r2 += $urandom_range(3, 15);
      if (r2 > 720) r2 = $urandom_range(60, 140);
      if ($urandom_range(0, 3) == 0) ru1 = 1 - ru1;
      if ($urandom_range(0, 3) == 0) ru2 = 1 - ru2;
      step("rnd", ru1, ru2, r1, r2);
    end

    do_reset("r8");
    step("t8a", 0, 0, 100, 100);
    step("t8b", 1, 0, 605, 110);
    step("t8c", 0, 0, 100, 120);
    step("t8d", 1, 0, 605, 130);
    step("t8e", 0, 0, 100, 140);
    check("t8_goods", score, 2);
    for (int n = 0; n < 10922; n++) begin
      step("sat", 1, 1, 620, 620);
      step("sat", 0, 0, 100, 100);
    end
    check("t8_preload", score, 65534);
    check("t8_combo_sat", combo, 255);
    step("t8f", 1, 0, 620, 150);
    check("t8_sat1", score, 65535);
    step("t8g", 0, 0, 100, 160);
    step("t8h", 1, 0, 620, 170);
    check("t8_sat2", score, 65535);
    check("t8_max_sat", max_combo, 255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
